// File: rtl/hiscore_pkg.sv
// Shared types and constants for the high-score / NVRAM bridge.
// The optional core pause request is enabled by defining HISCORE_PAUSE_EN.
package hiscore_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WR,
    RD,
    RD_WAIT
  } hs_state_t;

  localparam logic [7:0] HS_INDEX_DEFAULT = 8'hFF;
  localparam int         MAX_READ_LAT     = 3;

endpackage

// File: rtl/hiscore_lat_pipe.sv
// Valid shift register that delays a read launch by the core RAM latency,
// producing the strobe at which nv_dout is captured.
module hiscore_lat_pipe
  import hiscore_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic start,
  output logic done
);

  // Out-of-range latencies are clamped so the pipe always has a legal depth.
  localparam int DEPTH = (LAT < 1) ? 1 : ((LAT > MAX_READ_LAT) ? MAX_READ_LAT : LAT);

  logic [DEPTH-1:0] vld;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      vld <= '0;
    end else begin
      vld[0] <= start;
      for (int i = 1; i < DEPTH; i++) begin
        vld[i] <= vld[i-1];
      end
    end
  end

  assign done = vld[DEPTH-1];

endmodule

// File: rtl/hiscore_nvram_bridge.sv
// Bridges data_io image transfers to a byte-wide core NVRAM port with core-priority arbitration.
// Optional core pause request enabled by defining HISCORE_PAUSE_EN.
module hiscore_nvram_bridge
  import hiscore_pkg::*;
#(
  parameter int         AW       = 10,
  parameter int         SIZE     = 64,
  parameter int         READ_LAT = 1,
  parameter logic [7:0] HS_INDEX = HS_INDEX_DEFAULT
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          ioctl_download,
  input  logic          ioctl_upload,
  input  logic [7:0]    ioctl_index,
  input  logic          ioctl_wr,
  input  logic [24:0]   ioctl_addr,
  input  logic [7:0]    ioctl_dout,
  output logic [7:0]    ioctl_din,
  input  logic          core_busy,
  input  logic          core_nv_wr,
  output logic [AW-1:0] nv_addr,
  output logic [7:0]    nv_din,
  output logic          nv_we,
  output logic          nv_re,
  input  logic [7:0]    nv_dout,
  output logic          loaded,
  output logic          dirty,
  output logic          err,
  output logic          pause_o
);

  localparam logic [24:0] SIZE_L = 25'(SIZE);

  hs_state_t state, state_n;

  logic          sel, xfer_dn, xfer_up;
  logic          xfer_dn_q, xfer_up_q;
  logic [24:0]   addr_q;
  logic          up_trig, dn_fall, up_fall, trig_oob;
  logic          wr_strobe, wr_accept, wr_fire;

  logic          hold_valid;
  logic [AW-1:0] hold_addr;
  logic [7:0]    hold_data;

  logic          pend_valid, pend_oob;
  logic [AW-1:0] pend_addr;
  logic          req_valid, req_oob;
  logic [AW-1:0] req_addr;
  logic [AW-1:0] rd_addr;

  logic          pend_take, rd_launch, oob_hit, capture, lat_done;

  assign sel     = (ioctl_index == HS_INDEX);
  assign xfer_dn = ioctl_download & sel;
  assign xfer_up = ioctl_upload & sel;
  assign dn_fall = xfer_dn_q & ~xfer_dn;
  assign up_fall = xfer_up_q & ~xfer_up;

  // Prefetch fires when the upload starts or data_io moves to another address.
  assign up_trig  = xfer_up & (~xfer_up_q | (ioctl_addr != addr_q));
  assign trig_oob = (ioctl_addr >= SIZE_L);

  assign wr_strobe = ioctl_wr & xfer_dn;
  assign wr_accept = wr_strobe & (ioctl_addr < SIZE_L) & ~hold_valid;
  assign wr_fire   = (state == WR) & ~core_busy;

  // A fresh trigger overrides any older pending request.
  assign req_valid = up_trig | pend_valid;
  assign req_oob   = up_trig ? trig_oob : pend_oob;
  assign req_addr  = up_trig ? ioctl_addr[AW-1:0] : pend_addr;

  assign nv_we   = wr_fire;
  assign nv_re   = (state == RD) & ~core_busy;
  assign nv_addr = (state == WR) ? hold_addr : rd_addr;
  assign nv_din  = hold_data;

  hiscore_lat_pipe #(
    .LAT (READ_LAT)
  ) u_lat_pipe (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .start   (nv_re),
    .done    (lat_done)
  );

  // Pending writes win over reads; a read whose address went stale is not captured.
  always_comb begin
    state_n   = state;
    pend_take = 1'b0;
    rd_launch = 1'b0;
    oob_hit   = 1'b0;
    capture   = 1'b0;
    unique case (state)
      IDLE: begin
        if (hold_valid || wr_accept) begin
          state_n = WR;
        end else if (req_valid) begin
          pend_take = 1'b1;
          if (req_oob) begin
            oob_hit = 1'b1;
          end else begin
            rd_launch = 1'b1;
            state_n   = RD;
          end
        end
      end
      WR: begin
        if (!core_busy) state_n = IDLE;
      end
      RD: begin
        if (!core_busy) state_n = RD_WAIT;
      end
      RD_WAIT: begin
        if (lat_done) begin
          state_n = IDLE;
          capture = !(pend_valid || up_trig);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      xfer_dn_q <= 1'b0;
      xfer_up_q <= 1'b0;
      addr_q    <= '0;
    end else begin
      state     <= state_n;
      xfer_dn_q <= xfer_dn;
      xfer_up_q <= xfer_up;
      addr_q    <= ioctl_addr;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      hold_valid <= 1'b0;
      hold_addr  <= '0;
      hold_data  <= '0;
    end else if (wr_accept) begin
      hold_valid <= 1'b1;
      hold_addr  <= ioctl_addr[AW-1:0];
      hold_data  <= ioctl_dout;
    end else if (wr_fire) begin
      hold_valid <= 1'b0;
    end
  end

  // Requests are forgotten once the upload window closes.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      pend_valid <= 1'b0;
      pend_oob   <= 1'b0;
      pend_addr  <= '0;
      rd_addr    <= '0;
    end else begin
      if (pend_take || !xfer_up) begin
        pend_valid <= 1'b0;
      end else if (up_trig) begin
        pend_valid <= 1'b1;
        pend_oob   <= trig_oob;
        pend_addr  <= ioctl_addr[AW-1:0];
      end
      if (rd_launch) rd_addr <= req_addr;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      ioctl_din <= '0;
    end else if (capture) begin
      ioctl_din <= nv_dout;
    end else if (oob_hit) begin
      ioctl_din <= 8'h00;
    end
  end

  // A core write in the same cycle as the upload ending keeps the image dirty.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      loaded <= 1'b0;
      dirty  <= 1'b0;
      err    <= 1'b0;
    end else begin
      if (dn_fall) loaded <= 1'b1;
      if (core_nv_wr) begin
        dirty <= 1'b1;
      end else if (up_fall) begin
        dirty <= 1'b0;
      end
      if (wr_strobe && hold_valid) err <= 1'b1;
    end
  end

`ifdef HISCORE_PAUSE_EN
  logic pause_q, quiet;

  assign quiet = ~xfer_dn & ~xfer_up & (state == IDLE) & ~hold_valid;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      pause_q <= 1'b0;
    end else if ((xfer_dn & ~xfer_dn_q) | (xfer_up & ~xfer_up_q)) begin
      pause_q <= 1'b1;
    end else if (quiet) begin
      pause_q <= 1'b0;
    end
  end

  assign pause_o = pause_q & ~quiet;
`else
  assign pause_o = 1'b0;
`endif

endmodule

// File: tb/tb_hiscore_nvram_bridge.sv
// Randomised self-checking bench for hiscore_nvram_bridge (READ_LAT=2), with a
// transaction-level model of expected port writes and an addr+1 core RAM model.
module tb_hiscore_nvram_bridge;

  localparam int AW       = 10;
  localparam int SIZE     = 64;
  localparam int READ_LAT = 2;

`ifdef HISCORE_PAUSE_EN
  localparam logic PAUSE_EN = 1'b1;
`else
  localparam logic PAUSE_EN = 1'b0;
`endif

  logic          clk_sys;
  logic          reset_n;
  logic          ioctl_download;
  logic          ioctl_upload;
  logic [7:0]    ioctl_index;
  logic          ioctl_wr;
  logic [24:0]   ioctl_addr;
  logic [7:0]    ioctl_dout;
  logic [7:0]    ioctl_din;
  logic          core_busy;
  logic          core_nv_wr;
  logic [AW-1:0] nv_addr;
  logic [7:0]    nv_din;
  logic          nv_we;
  logic          nv_re;
  logic [7:0]    nv_dout;
  logic          loaded;
  logic          dirty;
  logic          err;
  logic          pause_o;

  int errors = 0;
  int checks = 0;
  int weCount = 0;
  int reCount = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } wr_t;

  wr_t expQ[$];

  hiscore_nvram_bridge #(
    .AW       (AW),
    .SIZE     (SIZE),
    .READ_LAT (READ_LAT),
    .HS_INDEX (8'hFF)
  ) dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .ioctl_download (ioctl_download),
    .ioctl_upload   (ioctl_upload),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_din      (ioctl_din),
    .core_busy      (core_busy),
    .core_nv_wr     (core_nv_wr),
    .nv_addr        (nv_addr),
    .nv_din         (nv_din),
    .nv_we          (nv_we),
    .nv_re          (nv_re),
    .nv_dout        (nv_dout),
    .loaded         (loaded),
    .dirty          (dirty),
    .err            (err),
    .pause_o        (pause_o)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // Core RAM model: every location reads back as its address plus one, READ_LAT=2.
  logic [7:0] rdStage = 8'h00;
  always @(posedge clk_sys) begin
    if (nv_re) rdStage <= 8'(nv_addr) + 8'd1;
    nv_dout <= rdStage;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Every port write is matched, in order, against the queue of accepted download bytes.
  always @(negedge clk_sys) begin
    if (reset_n && nv_we) begin
      weCount++;
      checkOutput("we_while_busy", 32'(core_busy), 32'd0);
      if (expQ.size() == 0) begin
        checkOutput("we_unexpected", 32'(nv_addr), 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = expQ.pop_front();
        checkOutput("we_addr", 32'(nv_addr), 32'(e.addr));
        checkOutput("we_data", 32'(nv_din), 32'(e.data));
      end
    end
    if (reset_n && nv_re) reCount++;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic driveWrite(input logic [24:0] a, input logic [7:0] d, input bit expectWrite);
    wr_t e;
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    if (expectWrite) begin
      e.addr = a[AW-1:0];
      e.data = d;
      expQ.push_back(e);
    end
    tick();
    ioctl_wr = 1'b0;
  endtask

  task automatic waitDrain(input string tag);
    int n = 0;
    while (expQ.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    checkOutput(tag, 32'(expQ.size()), 32'd0);
  endtask

  task automatic checkResetState(input string tag);
    @(negedge clk_sys);
    checkOutput({tag, "_din"},    32'(ioctl_din), 32'd0);
    checkOutput({tag, "_addr"},   32'(nv_addr),   32'd0);
    checkOutput({tag, "_nvdin"},  32'(nv_din),    32'd0);
    checkOutput({tag, "_we"},     32'(nv_we),     32'd0);
    checkOutput({tag, "_re"},     32'(nv_re),     32'd0);
    checkOutput({tag, "_loaded"}, 32'(loaded),    32'd0);
    checkOutput({tag, "_dirty"},  32'(dirty),     32'd0);
    checkOutput({tag, "_err"},    32'(err),       32'd0);
    checkOutput({tag, "_pause"},  32'(pause_o),   32'd0);
  endtask

  task automatic applyStimulus(input int testId);
    int order[SIZE];
    int tmp, j, s, a, b, lastB, n, reBefore, weBefore;
    logic [7:0] prevDin, d;
    bit stale, got;
    case (testId)
      1: begin
        // Foreign index and out-of-range addresses must never reach the port.
        ioctl_index    = 8'h00;
        ioctl_download = 1'b1;
        tick();
        driveWrite(25'd3, 8'h77, 1'b0);
        repeat (3) tick();
        ioctl_index = 8'hFF;
        tick();
        for (int i = 0; i < SIZE; i++) begin
          driveWrite(25'(i), 8'(i) ^ 8'h5A, 1'b1);
          repeat (3) tick();
          if (i == 32) begin
            @(negedge clk_sys);
            checkOutput("loaded_mid", 32'(loaded), 32'd0);
            checkOutput("pause_dl", 32'(pause_o), 32'(PAUSE_EN));
            tick();
          end
        end
        driveWrite(25'd100, 8'h99, 1'b0);
        repeat (3) tick();
        driveWrite(25'(SIZE), 8'h98, 1'b0);
        repeat (3) tick();
        waitDrain("dl_drain");
        ioctl_download = 1'b0;
        repeat (3) tick();
        @(negedge clk_sys);
        checkOutput("loaded_end", 32'(loaded), 32'd1);
        checkOutput("err_clean", 32'(err), 32'd0);
        checkOutput("pause_after_dl", 32'(pause_o), 32'd0);
        tick();
      end
      2: begin
        ioctl_index    = 8'hFF;
        ioctl_download = 1'b1;
        tick();
        for (int i = 0; i < SIZE; i++) begin
          core_busy = 1'b1;
          repeat (2) tick();
          d = 8'($urandom);
          driveWrite(25'(i), d, 1'b1);
          repeat (2) tick();
          @(negedge clk_sys);
          checkOutput("dl_stall_pending", 32'(expQ.size()), 32'd1);
          tick();
          core_busy = 1'b0;
          repeat ($urandom_range(2, 4)) tick();
        end
        waitDrain("dl_busy_drain");
        ioctl_download = 1'b0;
        repeat (2) tick();
      end
      3: begin
        for (int i = 0; i < SIZE; i++) order[i] = i;
        for (int i = SIZE - 1; i > 0; i--) begin
          j = $urandom_range(0, i);
          tmp = order[i];
          order[i] = order[j];
          order[j] = tmp;
        end
        prevDin      = ioctl_din;
        ioctl_index  = 8'hFF;
        ioctl_upload = 1'b1;
        for (int i = 0; i < SIZE; i++) begin
          s = (i % 8 == 7) ? $urandom_range(1, 4) : 0;
          ioctl_addr = 25'(order[i]);
          tick();
          if (s > 0) begin
            core_busy = 1'b1;
            repeat (s) tick();
            core_busy = 1'b0;
          end
          repeat (2) @(posedge clk_sys);
          @(negedge clk_sys);
          checkOutput("up_hold_old", 32'(ioctl_din), 32'(prevDin));
          @(posedge clk_sys);
          @(negedge clk_sys);
          prevDin = 8'(order[i] + 1);
          checkOutput("up_data", 32'(ioctl_din), 32'(prevDin));
          tick();
        end
        // Out-of-range addresses read as zero without touching the port.
        for (int k = 0; k < 2; k++) begin
          reBefore   = reCount;
          ioctl_addr = (k == 0) ? 25'd70 : 25'(SIZE);
          repeat (4) @(posedge clk_sys);
          @(negedge clk_sys);
          checkOutput("up_oob_data", 32'(ioctl_din), 32'd0);
          checkOutput("up_oob_no_re", 32'(reCount - reBefore), 32'd0);
          tick();
        end
        // An address change during a running read: only the newer data may appear.
        lastB = -1;
        for (int k = 0; k < 3; k++) begin
          do a = $urandom_range(0, SIZE - 1); while (a == lastB);
          do b = $urandom_range(0, SIZE - 1); while (b == lastB || b == a);
          reBefore   = reCount;
          ioctl_addr = 25'(a);
          tick();
          ioctl_addr = 25'(b);
          stale = 1'b0;
          got   = 1'b0;
          n     = 0;
          while (!got && n < 30) begin
            @(negedge clk_sys);
            if (ioctl_din == 8'(a + 1)) stale = 1'b1;
            if (ioctl_din == 8'(b + 1)) got = 1'b1;
            else tick();
            n++;
          end
          checkOutput("up_disc_stale", 32'(stale), 32'd0);
          checkOutput("up_disc_new", 32'(ioctl_din), 32'(b + 1));
          checkOutput("up_disc_reads", 32'(reCount - reBefore), 32'd2);
          tick();
          lastB = b;
        end
        ioctl_upload = 1'b0;
        repeat (2) tick();
        @(negedge clk_sys);
        checkOutput("pause_after_up", 32'(pause_o), 32'd0);
        tick();
      end
      4: begin
        ioctl_index    = 8'hFF;
        ioctl_download = 1'b1;
        core_busy      = 1'b1;
        tick();
        driveWrite(25'd5, 8'hAA, 1'b1);
        @(negedge clk_sys);
        checkOutput("err_before_second", 32'(err), 32'd0);
        tick();
        driveWrite(25'd6, 8'hBB, 1'b0);
        repeat (3) tick();
        @(negedge clk_sys);
        checkOutput("err_set", 32'(err), 32'd1);
        checkOutput("first_write_held", 32'(expQ.size()), 32'd1);
        tick();
        core_busy = 1'b0;
        repeat (4) tick();
        waitDrain("err_first_written");
        ioctl_download = 1'b0;
        repeat (4) tick();
        @(negedge clk_sys);
        checkOutput("err_sticky", 32'(err), 32'd1);
        tick();
      end
      5: begin
        core_nv_wr = 1'b1;
        tick();
        core_nv_wr = 1'b0;
        tick();
        @(negedge clk_sys);
        checkOutput("dirty_set", 32'(dirty), 32'd1);
        tick();
        ioctl_index  = 8'hFF;
        ioctl_addr   = 25'd3;
        ioctl_upload = 1'b1;
        repeat (8) tick();
        ioctl_upload = 1'b0;
        core_nv_wr   = 1'b1;
        tick();
        core_nv_wr = 1'b0;
        repeat (2) tick();
        @(negedge clk_sys);
        checkOutput("dirty_set_wins", 32'(dirty), 32'd1);
        tick();
        ioctl_upload = 1'b1;
        repeat (8) tick();
        ioctl_upload = 1'b0;
        repeat (2) tick();
        @(negedge clk_sys);
        checkOutput("dirty_cleared", 32'(dirty), 32'd0);
        tick();
        // Switching the index away ends the upload just like dropping ioctl_upload.
        core_nv_wr = 1'b1;
        tick();
        core_nv_wr   = 1'b0;
        ioctl_upload = 1'b1;
        repeat (6) tick();
        ioctl_index = 8'h00;
        repeat (2) tick();
        @(negedge clk_sys);
        checkOutput("dirty_index_change", 32'(dirty), 32'd0);
        tick();
        ioctl_upload = 1'b0;
        ioctl_index  = 8'hFF;
        repeat (2) tick();
      end
      6: begin
        weBefore       = weCount;
        ioctl_index    = 8'hFF;
        ioctl_download = 1'b1;
        core_busy      = 1'b1;
        tick();
        driveWrite(25'd9, 8'h3C, 1'b0);
        repeat (2) tick();
        reset_n = 1'b0;
        checkResetState("rst_mid");
        tick();
        ioctl_download = 1'b0;
        core_busy      = 1'b0;
        tick();
        reset_n = 1'b1;
        repeat (6) tick();
        @(negedge clk_sys);
        checkOutput("rst_no_we", 32'(weCount - weBefore), 32'd0);
        checkOutput("rst_err_clear", 32'(err), 32'd0);
        tick();
      end
      default: ;
    endcase
  endtask

  initial begin
    reset_n        = 1'b0;
    ioctl_download = 1'b0;
    ioctl_upload   = 1'b0;
    ioctl_index    = 8'h00;
    ioctl_wr       = 1'b0;
    ioctl_addr     = '0;
    ioctl_dout     = '0;
    core_busy      = 1'b0;
    core_nv_wr     = 1'b0;
    repeat (3) @(posedge clk_sys);
    checkResetState("rst_init");
    tick();
    reset_n = 1'b1;
    repeat (2) tick();

    $display("[TB] download, idle core");
    applyStimulus(1);
    $display("[TB] download, busy core");
    applyStimulus(2);
    $display("[TB] upload prefetch");
    applyStimulus(3);
    $display("[TB] dirty tracking");
    applyStimulus(5);
    $display("[TB] lost strobe");
    applyStimulus(4);
    $display("[TB] reset during write");
    applyStimulus(6);
    $display("[TB] download after reset");
    applyStimulus(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
